// File: rtl/memory_stage_pkg.sv
// Shared encodings for the memory-access stage: store/load modes,
// access sizes and FSM state codes.
package memory_stage_pkg;

    localparam logic [2:0] MSM_WORD = 3'b000;
    localparam logic [2:0] MSM_BYTE = 3'b001;
    localparam logic [2:0] MSM_HALF = 3'b010;

    localparam logic [2:0] MSL_WORD = 3'b000;
    localparam logic [2:0] MSL_BU   = 3'b001;
    localparam logic [2:0] MSL_BS   = 3'b010;
    localparam logic [2:0] MSL_HU   = 3'b011;
    localparam logic [2:0] MSL_HS   = 3'b100;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A store takes its size from msm, otherwise from msl.
    function automatic logic [1:0] access_size(
        input logic       store,
        input logic [2:0] msm,
        input logic [2:0] msl
    );
        logic [1:0] sz;
        sz = SZ_WORD;
        if (store) begin
            case (msm)
                MSM_BYTE: sz = SZ_BYTE;
                MSM_HALF: sz = SZ_HALF;
                default:  sz = SZ_WORD;
            endcase
        end else begin
            case (msl)
                MSL_BU, MSL_BS: sz = SZ_BYTE;
                MSL_HU, MSL_HS: sz = SZ_HALF;
                default:        sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/memory_stage_load_extend.sv
// Load lane select, zero/sign extension and halfword merge.
module load_extend
    import memory_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  msl,
    input  logic        mshw,
    input  logic        lshw,
    input  logic [31:0] regb,
    output logic [31:0] value
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = off[1] ? rdata[31:16] : rdata[15:0];
        value   = rdata;
        case (msl)
            MSL_BU: value = {24'b0, byte_v};
            MSL_BS: value = {{24{byte_v[7]}}, byte_v};
            MSL_HU, MSL_HS: begin
                if (mshw)
                    value = {half_v, regb[15:0]};
                else if (lshw)
                    value = {regb[31:16], half_v};
                else if (msl == MSL_HS)
                    value = {{16{half_v[15]}}, half_v};
                else
                    value = {16'b0, half_v};
            end
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory-access stage: drives the data-memory handshake, stalls the
// front of the pipeline while an access is outstanding, fills MEM/WB.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        ex_mem_msm,
    input  logic [2:0]        ex_mem_msl,
    input  logic              ex_mem_readmem,
    input  logic              ex_mem_writemem,
    input  logic              ex_mem_mshw,
    input  logic              ex_mem_lshw,
    input  logic [31:0]       ex_mem_regb,
    input  logic [2:0]        ex_mem_selwsource,
    input  logic [4:0]        ex_mem_regdest,
    input  logic              ex_mem_writereg,
    input  logic [31:0]       ex_mem_aluout,
    input  logic [31:0]       ex_mem_wbvalue,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              mem_if_stall,
    output logic              mem_misalign,
    output logic [2:0]        mem_wb_selwsource,
    output logic [4:0]        mem_wb_regdest,
    output logic              mem_wb_writereg,
    output logic [31:0]       mem_wb_value,
    output logic [31:0]       mem_fw_value,
    output logic [4:0]        mem_fw_regdest,
    output logic              mem_fw_writereg
);

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              misalign_q, misalign_d;
    logic [2:0]        wb_sel_q, wb_sel_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_wr_q, wb_wr_d;
    logic [31:0]       wb_val_q, wb_val_d;

    logic        access;
    logic [1:0]  size;
    logic [1:0]  off;
    logic        aligned;
    logic        pending;
    logic        misalign_now;
    logic        load_done;
    logic        stall;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] ld_value;

    load_extend u_load_extend (
        .rdata (rdata_q),
        .off   (ex_mem_aluout[1:0]),
        .msl   (ex_mem_msl),
        .mshw  (ex_mem_mshw),
        .lshw  (ex_mem_lshw),
        .regb  (ex_mem_regb),
        .value (ld_value)
    );

    always_comb begin
        access = ex_mem_readmem | ex_mem_writemem;
        size   = access_size(ex_mem_writemem, ex_mem_msm, ex_mem_msl);
        off    = ex_mem_aluout[1:0];
        case (size)
            SZ_WORD: aligned = (off == 2'b00);
            SZ_HALF: aligned = ~off[0];
            default: aligned = 1'b1;
        endcase
        pending      = access & aligned;
        misalign_now = (state_q == ST_IDLE) & access & ~aligned;
        load_done    = (state_q == ST_DONE) & ex_mem_readmem
                       & ~ex_mem_writemem;
        stall        = ((state_q == ST_IDLE) & pending)
                       | (state_q == ST_REQ);
    end

    // Store data is replicated so every enabled lane sees it.
    always_comb begin
        case (size)
            SZ_WORD: begin
                be_new    = 4'b1111;
                wdata_new = ex_mem_regb;
            end
            SZ_HALF: begin
                be_new    = off[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{ex_mem_regb[15:0]}};
            end
            default: begin
                be_new    = 4'b0001 << off;
                wdata_new = {4{ex_mem_regb[7:0]}};
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_now;
        wb_sel_d   = wb_sel_q;
        wb_rd_d    = wb_rd_q;
        wb_wr_d    = wb_wr_q;
        wb_val_d   = wb_val_q;

        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = ex_mem_writemem;
                    addr_d  = {ex_mem_aluout[ADDR_W-1:2], 2'b00};
                    be_d    = be_new;
                    wdata_d = wdata_new;
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'b0000;
                    rdata_d = dmem_rdata;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (stall) begin
            wb_wr_d = 1'b0;
        end else begin
            wb_sel_d = ex_mem_selwsource;
            wb_rd_d  = ex_mem_regdest;
            wb_wr_d  = ex_mem_writereg & ~misalign_now;
            wb_val_d = load_done ? ld_value : ex_mem_wbvalue;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'b0;
            rdata_q    <= 32'b0;
            misalign_q <= 1'b0;
            wb_sel_q   <= 3'b0;
            wb_rd_q    <= 5'b0;
            wb_wr_q    <= 1'b0;
            wb_val_q   <= 32'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            wb_sel_q   <= wb_sel_d;
            wb_rd_q    <= wb_rd_d;
            wb_wr_q    <= wb_wr_d;
            wb_val_q   <= wb_val_d;
        end
    end

    assign dmem_req          = req_q;
    assign dmem_we           = we_q;
    assign dmem_addr         = addr_q;
    assign dmem_be           = be_q;
    assign dmem_wdata        = wdata_q;
    assign mem_if_stall      = stall;
    assign mem_misalign      = misalign_q;
    assign mem_wb_selwsource = wb_sel_q;
    assign mem_wb_regdest    = wb_rd_q;
    assign mem_wb_writereg   = wb_wr_q;
    assign mem_wb_value      = wb_val_q;
    assign mem_fw_value      = wb_val_q;
    assign mem_fw_regdest    = wb_rd_q;
    assign mem_fw_writereg   = wb_wr_q;

endmodule
